// File: rtl/bits_pkg.sv
// rtl/bits_pkg.sv - shared types and constants for the bits lock controller
package bits_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DRST,
        ST_SEARCH,
        ST_LOCKED,
        ST_DONE,
        ST_FAIL
    } state_t;

    // Detector reset pulse length; the detector latches its bank while in reset.
    localparam int DRST_CYCLES = 2;

    // Width of a bank select; a single bank still needs one bit of port.
    function automatic int bank_width(input int banks);
        return (banks > 1) ? $clog2(banks) : 1;
    endfunction

endpackage

// File: rtl/preamble_matcher.sv
// rtl/preamble_matcher.sv - preamble shift register and compare
// Ports: clk, rst (async, active-high), clr (sync clear), en (shift enable),
//        det_dat/det_vld (detector bit stream), match (combinational hit).
module preamble_matcher #(
    parameter int                PRE_LEN  = 6,
    parameter logic [PRE_LEN-1:0] PREAMBLE = 6'b101011
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    input  logic det_dat,
    input  logic det_vld,
    output logic match
);

    logic [PRE_LEN-1:0] sr;
    logic [PRE_LEN-1:0] sr_nxt;

    // LSB-in, so the first received bit ends up at the MSB.
    assign sr_nxt = {sr[PRE_LEN-2:0], det_dat};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr <= '0;
        end else if (clr) begin
            sr <= '0;
        end else if (en && det_vld) begin
            sr <= sr_nxt;
        end
    end

    // Compare against the value including the bit arriving this cycle.
    assign match = en && det_vld && (sr_nxt == PREAMBLE);

endmodule

// File: rtl/bits_lock_controller.sv
// rtl/bits_lock_controller.sv - sweeps detector banks until preamble lock, then forwards a frame
// Ports: clk, rst (async, active-high), start (acquisition request),
//        det_dat/det_vld (detector bits), det_rst/frequency_bank (detector control),
//        out_dat/out_vld (payload), locked, done/fail (one-cycle pulses).
// Option: BITS_LOCK_BANK_MEMORY_EN - start each sweep at the last locked bank.
module bits_lock_controller
    import bits_pkg::*;
#(
    parameter int                BANKS      = 4,
    parameter int                PRE_LEN    = 6,
    parameter logic [PRE_LEN-1:0] PREAMBLE   = 6'b101011,
    parameter int                TIMEOUT    = 64,
    parameter int                FRAME_BITS = 128
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic                         det_dat,
    input  logic                         det_vld,
    output logic                         det_rst,
    output logic [bank_width(BANKS)-1:0] frequency_bank,
    output logic                         out_dat,
    output logic                         out_vld,
    output logic                         locked,
    output logic                         done,
    output logic                         fail
);

    localparam int BANK_W  = bank_width(BANKS);
    localparam int CNT_MAX = (TIMEOUT > FRAME_BITS) ? TIMEOUT : FRAME_BITS;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int TRIED_W = $clog2(BANKS + 1);
    localparam int DRST_W  = (DRST_CYCLES > 1) ? $clog2(DRST_CYCLES) : 1;

    state_t              state;
    state_t              state_nxt;
    logic [CNT_W-1:0]    bit_cnt;
    logic [CNT_W-1:0]    bit_cnt_inc;
    logic [TRIED_W-1:0]  tried;
    logic [TRIED_W-1:0]  tried_inc;
    logic [DRST_W-1:0]   drst_cnt;
    logic [BANK_W-1:0]   start_bank;
    logic [BANK_W-1:0]   next_bank;
    logic                match;
    logic                hit;
    logic                timeout;
    logic                last_bank;
    logic                drst_last;
    logic                frame_full;
    logic                fwd;

    preamble_matcher #(
        .PRE_LEN  (PRE_LEN),
        .PREAMBLE (PREAMBLE)
    ) u_matcher (
        .clk     (clk),
        .rst     (rst),
        .clr     (state == ST_DRST),
        .en      (state == ST_SEARCH),
        .det_dat (det_dat),
        .det_vld (det_vld),
        .match   (match)
    );

    assign bit_cnt_inc = bit_cnt + 1'b1;
    assign tried_inc   = tried + 1'b1;
    // A match needs a full preamble's worth of bits since the bank started.
    assign hit         = match && (bit_cnt_inc >= CNT_W'(PRE_LEN));
    assign timeout     = det_vld && (bit_cnt_inc == CNT_W'(TIMEOUT));
    assign last_bank   = (tried_inc == TRIED_W'(BANKS));
    assign next_bank   = (frequency_bank == BANK_W'(BANKS - 1)) ? '0 : frequency_bank + 1'b1;
    assign drst_last   = (drst_cnt == DRST_W'(DRST_CYCLES - 1));
    // The frame count saturates at FRAME_BITS so a late det_vld is never forwarded.
    assign frame_full  = (bit_cnt == CNT_W'(FRAME_BITS));
    assign fwd         = (state == ST_LOCKED) && det_vld && !frame_full;

`ifdef BITS_LOCK_BANK_MEMORY_EN
    logic [BANK_W-1:0] mem_bank;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_bank <= '0;
        end else if (state == ST_SEARCH && hit) begin
            mem_bank <= frequency_bank;
        end
    end

    assign start_bank = mem_bank;
`else
    assign start_bank = '0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        det_rst   = 1'b1;
        locked    = 1'b0;
        done      = 1'b0;
        fail      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) state_nxt = ST_DRST;
            end
            ST_DRST: begin
                if (drst_last) state_nxt = ST_SEARCH;
            end
            ST_SEARCH: begin
                det_rst = 1'b0;
                if (hit) begin
                    state_nxt = ST_LOCKED;
                end else if (timeout) begin
                    state_nxt = last_bank ? ST_FAIL : ST_DRST;
                end
            end
            ST_LOCKED: begin
                det_rst = 1'b0;
                locked  = 1'b1;
                if (frame_full) state_nxt = ST_DONE;
            end
            ST_DONE: begin
                done      = 1'b1;
                state_nxt = ST_IDLE;
            end
            ST_FAIL: begin
                fail      = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frequency_bank <= '0;
            bit_cnt        <= '0;
            tried          <= '0;
            drst_cnt       <= '0;
            out_dat        <= 1'b0;
            out_vld        <= 1'b0;
        end else begin
            out_vld <= fwd;
            if (fwd) out_dat <= det_dat;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        frequency_bank <= start_bank;
                        tried          <= '0;
                    end
                end
                ST_DRST: begin
                    drst_cnt <= drst_last ? '0 : drst_cnt + 1'b1;
                    bit_cnt  <= '0;
                end
                ST_SEARCH: begin
                    if (hit) begin
                        bit_cnt <= '0;
                    end else if (timeout) begin
                        tried <= tried_inc;
                        // On the final bank the select stays put for inspection.
                        if (!last_bank) frequency_bank <= next_bank;
                    end else if (det_vld) begin
                        bit_cnt <= bit_cnt_inc;
                    end
                end
                ST_LOCKED: begin
                    if (fwd) bit_cnt <= bit_cnt_inc;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bits_lock_controller.sv
// tb/tb_bits_lock_controller.sv - scoreboard bench for bits_lock_controller
module tb_bits_lock_controller;

    localparam int FRAME = 128;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       det_dat;
    logic       det_vld;
    logic       det_rst;
    logic [1:0] frequency_bank;
    logic       out_dat;
    logic       out_vld;
    logic       locked;
    logic       done;
    logic       fail;

    int   n_cmp = 0;
    int   n_err = 0;
    int   pulse_cnt = 0;
    int   fail_cnt = 0;
    logic exp_q[$];
    logic mon_exp;
    logic [5:0] pre_v;

    bits_lock_controller #(
        .BANKS      (4),
        .PRE_LEN    (6),
        .PREAMBLE   (6'b101011),
        .TIMEOUT    (64),
        .FRAME_BITS (FRAME)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .det_dat        (det_dat),
        .det_vld        (det_vld),
        .det_rst        (det_rst),
        .frequency_bank (frequency_bank),
        .out_dat        (out_dat),
        .out_vld        (out_vld),
        .locked         (locked),
        .done           (done),
        .fail           (fail)
    );

    always #5 clk = ~clk;

    // Scoreboard: every out_vld pops the oldest payload bit driven.
    always @(negedge clk) begin
        if (rst === 1'b0 && out_vld === 1'b1) begin
            pulse_cnt++;
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL payload_extra: out_vld with out_dat=%0b, no bit required", out_dat);
            end else begin
                mon_exp = exp_q.pop_front();
                if (out_dat !== mon_exp) begin
                    n_err++;
                    $display("FAIL payload_bit: out_dat=%0b required %0b", out_dat, mon_exp);
                end
            end
        end
        if (rst === 1'b0 && fail === 1'b1) fail_cnt++;
    end

    task automatic drive_bit(input logic b);
        det_dat = b;
        det_vld = 1'b1;
        @(negedge clk);
    endtask

    // Two DRST cycles with junk det_vld that must be ignored, ending in SEARCH.
    task automatic expect_drst(input int bank, input string tag);
        det_dat = 1'b1;
        det_vld = 1'b1;
        for (int c = 0; c < 2; c++) begin
            n_cmp++;
            if (det_rst !== 1'b1) begin n_err++; $display("FAIL %s_drst_rst: det_rst=%0b required 1 (cycle %0d)", tag, det_rst, c); end
            n_cmp++;
            if (frequency_bank !== 2'(bank)) begin n_err++; $display("FAIL %s_bank: frequency_bank=%0d required %0d", tag, frequency_bank, bank); end
            @(negedge clk);
        end
        det_vld = 1'b0;
        n_cmp++;
        if (det_rst !== 1'b0) begin n_err++; $display("FAIL %s_search_rst: det_rst=%0b required 0", tag, det_rst); end
    endtask

    task automatic do_start(input int bank, input string tag);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        expect_drst(bank, tag);
    endtask

    task automatic send_preamble(input string tag);
        for (int i = 5; i >= 0; i--) begin
            drive_bit(pre_v[i]);
            n_cmp++;
            if (locked !== (i == 0)) begin n_err++; $display("FAIL %s_locked: locked=%0b required %0b after preamble bit %0d", tag, locked, (i == 0), 6 - i); end
        end
    endtask

    task automatic send_payload(input int n);
        logic b;
        for (int k = 0; k < n; k++) begin
            b = 1'($urandom_range(0, 1));
            exp_q.push_back(b);
            drive_bit(b);
        end
    endtask

    // Random bits that never form the preamble, counted from a cleared history.
    task automatic send_noise(input int n, input string tag);
        logic [5:0] h;
        logic       b;
        h = '0;
        for (int k = 0; k < n; k++) begin
            b = 1'($urandom_range(0, 1));
            if ({h[4:0], b} == pre_v) b = ~b;
            h = {h[4:0], b};
            drive_bit(b);
            n_cmp++;
            if (locked !== 1'b0) begin n_err++; $display("FAIL %s_noise_lock: locked=%0b required 0 at bit %0d", tag, locked, k + 1); end
        end
    endtask

    task automatic finish_frame(input string tag);
        n_cmp++;
        if (out_vld !== 1'b1) begin n_err++; $display("FAIL %s_last_vld: out_vld=%0b required 1", tag, out_vld); end
        n_cmp++;
        if (done !== 1'b0) begin n_err++; $display("FAIL %s_done_early: done=%0b required 0", tag, done); end
        det_vld = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (done !== 1'b1) begin n_err++; $display("FAIL %s_done: done=%0b required 1", tag, done); end
        n_cmp++;
        if (out_vld !== 1'b0) begin n_err++; $display("FAIL %s_vld_after: out_vld=%0b required 0", tag, out_vld); end
        n_cmp++;
        if (locked !== 1'b0) begin n_err++; $display("FAIL %s_unlock: locked=%0b required 0", tag, locked); end
        @(negedge clk);
        n_cmp++;
        if (done !== 1'b0) begin n_err++; $display("FAIL %s_done_len: done=%0b required 0", tag, done); end
        n_cmp++;
        if (det_rst !== 1'b1) begin n_err++; $display("FAIL %s_idle_rst: det_rst=%0b required 1", tag, det_rst); end
        n_cmp++;
        if (pulse_cnt !== FRAME) begin n_err++; $display("FAIL %s_pulses: out_vld pulses=%0d required %0d", tag, pulse_cnt, FRAME); end
        n_cmp++;
        if (exp_q.size() != 0) begin n_err++; $display("FAIL %s_pending: %0d bits not forwarded, required 0", tag, exp_q.size()); end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; det_vld = 1'b0; det_dat = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({det_rst, frequency_bank, out_dat, out_vld, locked, done, fail} !== 8'b1_00_00000) begin
            n_err++; $display("FAIL reset_outputs: got %b required 10000000", {det_rst, frequency_bank, out_dat, out_vld, locked, done, fail});
        end
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (det_rst !== 1'b1 || locked !== 1'b0) begin n_err++; $display("FAIL reset_idle: det_rst=%0b locked=%0b required 1/0", det_rst, locked); end
    endtask

    task automatic test_lock_bank0();
        do_start(0, "lock0");
        send_preamble("lock0");
        pulse_cnt = 0;
        start = 1'b1;
        send_payload(1);
        start = 1'b0;
        send_payload(FRAME - 1);
        finish_frame("lock0");
    endtask

    task automatic test_bank_step();
        do_start(0, "step_b0");
        send_noise(64, "step_b0");
        expect_drst(1, "step_b1");
        send_noise(64, "step_b1");
        expect_drst(2, "step_b2");
        send_preamble("step");
        n_cmp++;
        if (frequency_bank !== 2'd2) begin n_err++; $display("FAIL step_lock_bank: frequency_bank=%0d required 2", frequency_bank); end
        pulse_cnt = 0;
        send_payload(FRAME);
        finish_frame("step");
    endtask

    task automatic test_bank_memory();
`ifdef BITS_LOCK_BANK_MEMORY_EN
        do_start(2, "mem");
`else
        do_start(0, "mem");
`endif
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        @(negedge clk);
    endtask

    task automatic test_exhaustion();
        fail_cnt = 0;
        do_start(0, "exh_b0");
        for (int b = 0; b < 4; b++) begin
            send_noise(64, "exh");
            if (b < 3) expect_drst(b + 1, "exh_step");
        end
        n_cmp++;
        if (fail !== 1'b1) begin n_err++; $display("FAIL exh_fail: fail=%0b required 1", fail); end
        n_cmp++;
        if (frequency_bank !== 2'd3) begin n_err++; $display("FAIL exh_bank: frequency_bank=%0d required 3", frequency_bank); end
        @(negedge clk);
        n_cmp++;
        if (fail !== 1'b0 || det_rst !== 1'b1) begin n_err++; $display("FAIL exh_idle: fail=%0b det_rst=%0b required 0/1", fail, det_rst); end
        n_cmp++;
        if (frequency_bank !== 2'd3) begin n_err++; $display("FAIL exh_bank_kept: frequency_bank=%0d required 3", frequency_bank); end
        n_cmp++;
        if (fail_cnt !== 1) begin n_err++; $display("FAIL exh_fail_pulses: fail pulses=%0d required 1", fail_cnt); end
    endtask

    task automatic test_match_on_timeout();
        do_start(0, "mot");
        for (int k = 0; k < 58; k++) drive_bit(1'b0);
        send_preamble("mot");
        n_cmp++;
        if (frequency_bank !== 2'd0 || det_rst !== 1'b0) begin n_err++; $display("FAIL mot_no_step: bank=%0d det_rst=%0b required 0/0", frequency_bank, det_rst); end
        pulse_cnt = 0;
        send_payload(FRAME);
        finish_frame("mot");
    endtask

    task automatic test_async_reset();
        do_start(0, "arst");
        send_preamble("arst");
        pulse_cnt = 0;
        send_payload(40);
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if ({out_vld, locked, done, det_rst} !== 4'b0001) begin
            n_err++; $display("FAIL arst_outputs: out_vld/locked/done/det_rst=%b required 0001", {out_vld, locked, done, det_rst});
        end
        n_cmp++;
        if (pulse_cnt !== 40) begin n_err++; $display("FAIL arst_pulses: out_vld pulses=%0d required 40", pulse_cnt); end
        det_vld = 1'b0;
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        do_start(0, "arst_again");
        send_preamble("arst_again");
        pulse_cnt = 0;
        send_payload(FRAME);
        finish_frame("arst_again");
    endtask

    initial begin
        pre_v = 6'b101011;
        test_reset();
        test_lock_bank0();
        test_bank_step();
        test_bank_memory();
        test_exhaustion();
        test_match_on_timeout();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: bench did not complete within time limit");
        $fatal(1);
    end

endmodule
